// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes,
// frame length and the odd-parity helper used on both directions of the link.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_XFER      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;
    localparam logic [7:0] PS2_RESEND      = 8'hFE;

    localparam int PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a registered
// falling-edge strobe on the synchronized clock; shared with the receive path.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);

    logic clk_m;
    logic data_m;

    // Reset to the idle (released, pulled-up) level so no false edge follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_m    <= 1'b1;
            clk_s    <= 1'b1;
            data_m   <= 1'b1;
            data_s   <= 1'b1;
            clk_fall <= 1'b0;
        end else begin
            clk_m    <= ps2_clk_i;
            clk_s    <= clk_m;
            data_m   <= ps2_data_i;
            data_s   <= data_m;
            clk_fall <= clk_s & ~clk_m;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send, then
// shifts out one command byte on device clock falls and checks the device ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic [2:0] state_dbg
);

    // Handshake: a byte is taken on any clock edge where tx_valid && tx_ready;
    // tx_ready is only high in IDLE, so tx_valid is ignored for a whole frame.

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_INHIBIT   = ST_INHIBIT;
    localparam logic [2:0] S_RTS       = ST_RTS;
    localparam logic [2:0] S_XFER      = ST_XFER;
    localparam logic [2:0] S_WAIT_IDLE = ST_WAIT_IDLE;

    localparam int DLY_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int DW      = $clog2(DLY_MAX + 1);

    localparam logic [DW-1:0] INH_LAST = DW'(INHIBIT_CYCLES - 1);
    localparam logic [DW-1:0] RTS_LAST = DW'(RTS_CYCLES - 1);
    localparam logic [20:0]   TO_LAST  = 21'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    ACK_BIT  = 4'(PS2_FRAME_BITS - 1);

    logic [2:0]    state;
    logic [DW-1:0] dly_cnt;
    logic [3:0]    bit_cnt;
    logic [20:0]   to_cnt;
    logic [7:0]    tx_byte;
    logic          parity;
    logic          clk_s;
    logic          data_s;
    logic          clk_fall;
    logic          to_hit;

    ps2_line_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .clk_fall   (clk_fall)
    );

    assign to_hit    = (to_cnt == TO_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            dly_cnt     <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            tx_byte     <= '0;
            parity      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_byte     <= tx_data;
                        parity      <= odd_parity(tx_data);
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b0;
                        tx_busy     <= 1'b1;
                        dly_cnt     <= '0;
                        state       <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (dly_cnt == INH_LAST) begin
                        dly_cnt     <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= S_RTS;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                S_RTS: begin
                    if (dly_cnt == RTS_LAST) begin
                        dly_cnt    <= '0;
                        ps2_clk_oe <= 1'b0;
                        bit_cnt    <= '0;
                        to_cnt     <= '0;
                        state      <= S_XFER;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (to_cnt != '1) to_cnt <= to_cnt + 21'd1;
                    // Timeout is checked first so it wins over a coincident ack sample.
                    if (to_hit) begin
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        tx_ready    <= 1'b1;
                        tx_busy     <= 1'b0;
                        state       <= S_IDLE;
                    end else if (clk_fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8) begin
                            ps2_data_oe <= ~tx_byte[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            ps2_data_oe <= ~parity;
                        end else if (bit_cnt != ACK_BIT) begin
                            ps2_data_oe <= 1'b0;
                        end else if (!data_s) begin
                            ps2_data_oe <= 1'b0;
                            state       <= S_WAIT_IDLE;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            tx_err      <= 1'b1;
                            tx_ready    <= 1'b1;
                            tx_busy     <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (to_cnt != '1) to_cnt <= to_cnt + 21'd1;
                    if (to_hit) begin
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        tx_ready    <= 1'b1;
                        tx_busy     <= 1'b0;
                        state       <= S_IDLE;
                    end else if (clk_s && data_s) begin
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    tx_busy     <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on the pins plus a timeline model
// of the host outputs derived from accept time, pin fall times and the ack level.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int TB_INHIBIT = 2000;
    localparam int TB_RTS     = 200;
    localparam int TB_TIMEOUT = 6000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [2:0] state_dbg;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_pin, ps2_data_pin;

    assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (TB_INHIBIT),
        .RTS_CYCLES     (TB_RTS),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_i   (ps2_clk_pin),
        .ps2_data_i  (ps2_data_pin),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // ---------------- reference model (timeline) ----------------
    bit e_clk_oe = 0, e_data_oe = 0, e_ready = 1, e_busy = 0, e_done = 0, e_err = 0;
    bit m_busy = 0, m_wait = 0;
    int acc_t, rel_t, n_act;
    logic [7:0] m_byte;
    logic pc_prev = 1'b1, ph1 = 1'b1, ph2 = 1'b1;
    int   act_q[$];
    logic act_d_q[$];

    always @(posedge clk) begin : model
        int e;
        bit fall_now, fin_done, fin_err;
        logic fd, pc, pd;
        cyc = cyc + 1;
        e = cyc;
        if (rst) begin
            m_busy = 0; m_wait = 0; pc_prev = 1'b1; ph1 = 1'b1; ph2 = 1'b1;
            act_q.delete(); act_d_q.delete();
            e_clk_oe = 0; e_data_oe = 0; e_ready = 1; e_busy = 0; e_done = 0; e_err = 0;
        end else begin
            pc = ps2_clk_pin;
            pd = ps2_data_pin;
            // a pin fall seen at edge e is acted on two edges later, with the data seen at e
            if (pc_prev && !pc) begin
                act_q.push_back(e + 2);
                act_d_q.push_back(pd);
            end
            pc_prev = pc;
            fall_now = 0; fd = 1'b1; fin_done = 0; fin_err = 0;
            while (act_q.size() > 0 && act_q[0] <= e) begin
                if (act_q[0] == e) begin
                    fall_now = 1;
                    fd = act_d_q[0];
                end
                void'(act_q.pop_front());
                void'(act_d_q.pop_front());
            end
            if (!m_busy) begin
                if (tx_valid) begin
                    m_busy = 1; m_wait = 0; n_act = 0;
                    acc_t = e; rel_t = e + TB_INHIBIT + TB_RTS; m_byte = tx_data;
                end
            end else if (e > rel_t) begin
                if (e == rel_t + TB_TIMEOUT) fin_err = 1;
                else if (m_wait) begin
                    if (ph2) fin_done = 1;
                end else if (fall_now) begin
                    n_act++;
                    if (n_act == 11) begin
                        if (fd == 1'b0) m_wait = 1;
                        else fin_err = 1;
                    end
                end
            end
            if (fin_done || fin_err) m_busy = 0;
            e_done = fin_done;
            e_err  = fin_err;
            e_ready = !m_busy;
            e_busy  = m_busy;
            if (!m_busy) begin
                e_clk_oe = 0; e_data_oe = 0;
            end else begin
                e_clk_oe = (e < rel_t);
                if (e < acc_t + TB_INHIBIT) e_data_oe = 0;
                else if (e < rel_t) e_data_oe = 1;
                else if (m_wait) e_data_oe = 0;
                else if (n_act == 0) e_data_oe = 1;
                else if (n_act <= 8) e_data_oe = ~m_byte[n_act-1];
                else if (n_act == 9) e_data_oe = ~(~^m_byte);
                else e_data_oe = 0;
            end
            ph2 = ph1;
            ph1 = pc & pd;
        end
    end

    // ---------------- per-cycle compare + event monitor ----------------
    int n_done = 0, n_err = 0;
    int t_clk_rise = 0, t_clk_fall = 0, t_data_rise = 0, t_done = 0, t_err = 0;
    logic p_clk_oe = 1'b0, p_data_oe = 1'b0;

    always @(negedge clk) begin
        check("outputs{clk_oe,data_oe,ready,busy,done,err,idle}",
              {ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy, tx_done, tx_err, (state_dbg == 3'(ST_IDLE))},
              {e_clk_oe, e_data_oe, e_ready, e_busy, e_done, e_err, !e_busy});
        if (ps2_clk_oe && !p_clk_oe) t_clk_rise = cyc;
        if (!ps2_clk_oe && p_clk_oe) t_clk_fall = cyc;
        if (ps2_data_oe && !p_data_oe && ps2_clk_oe) t_data_rise = cyc;
        if (tx_done) begin n_done++; t_done = cyc; end
        if (tx_err) begin n_err++; t_err = cyc; end
        p_clk_oe  = ps2_clk_oe;
        p_data_oe = ps2_data_oe;
    end

    // ---------------- driver / device tasks ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic device(input int half, input int npulse, input bit ack,
                          output logic [10:0] cap, output bit ok);
        int w;
        cap = '1;
        ok = 0;
        w = 0;
        while (!(ps2_clk_pin && !ps2_data_pin) && w < TB_INHIBIT + TB_RTS + 200) begin
            @(negedge clk);
            w++;
        end
        if (!(ps2_clk_pin && !ps2_data_pin)) return;
        ok = 1;
        repeat (10) @(negedge clk);
        cap[0] = ps2_data_pin;
        for (int i = 1; i <= npulse; i++) begin
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i <= 10) cap[i] = ps2_data_pin;
            if (i == 10 && ack) dev_data_low = 1'b1;
            repeat (half) @(negedge clk);
            if (i == 11) dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_end(input int base);
        int w;
        w = 0;
        while (n_done + n_err == base && w < TB_INHIBIT + TB_RTS + TB_TIMEOUT + 500) begin
            @(posedge clk);
            w++;
        end
        check("frame_end_seen", 32'(n_done + n_err != base), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [10:0] cap;
        bit ok;
        int bd, be, half;
        logic [7:0] b;
        bit ack;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 32'(tx_ready), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 32'd0);

        // 0xED, compliant device
        bd = n_done; be = n_err;
        send(PS2_CMD_SET_LED);
        device(20, 11, 1'b1, cap, ok);
        check("ed_release_seen", 32'(ok), 32'd1);
        wait_end(bd + be);
        check("ed_bits", 32'(cap), 32'h7DA);
        check("ed_done_once", 32'(n_done - bd), 32'd1);
        check("ed_no_err", 32'(n_err - be), 32'd0);

        // 0xF4 with inhibit / RTS timing
        bd = n_done; be = n_err;
        send(PS2_CMD_ENABLE);
        device(16, 11, 1'b1, cap, ok);
        wait_end(bd + be);
        check("f4_bits", 32'(cap), 32'h5E8);
        check("f4_inhibit_len", 32'(t_data_rise - t_clk_rise), 32'(TB_INHIBIT));
        check("f4_rts_len", 32'(t_clk_fall - t_data_rise), 32'(TB_RTS));
        check("f4_done_once", 32'(n_done - bd), 32'd1);

        // no ack
        bd = n_done; be = n_err;
        send(8'h3C);
        device(15, 11, 1'b0, cap, ok);
        wait_end(bd + be);
        check("noack_err", 32'(n_err - be), 32'd1);
        check("noack_no_done", 32'(n_done - bd), 32'd0);
        check("noack_lines", {ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("noack_ready", 32'(tx_ready), 32'd1);

        // device never clocks
        bd = n_done; be = n_err;
        send(PS2_CMD_RESET);
        device(10, 0, 1'b0, cap, ok);
        wait_end(bd + be);
        check("timeout_err", 32'(n_err - be), 32'd1);
        check("timeout_len", 32'(t_err - t_clk_fall), 32'(TB_TIMEOUT));
        check("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 32'd0);

        // busy + back-to-back: 0xFF held during a 0xED frame
        bd = n_done; be = n_err;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = PS2_CMD_SET_LED;
        @(negedge clk);
        tx_data = PS2_CMD_RESET;
        device(20, 11, 1'b1, cap, ok);
        wait_end(bd + be);
        tx_valid = 1'b0;
        check("b2b_first_bits", 32'(cap), 32'h7DA);
        check("b2b_first_done", 32'(n_done - bd), 32'd1);
        check("b2b_accept_after_done", 32'(t_clk_rise - t_done), 32'd1);
        bd = n_done; be = n_err;
        device(18, 11, 1'b1, cap, ok);
        wait_end(bd + be);
        check("b2b_second_bits", 32'(cap), 32'h7FE);
        check("b2b_second_done", 32'(n_done - bd), 32'd1);

        // reset mid-frame after the 5th falling edge
        bd = n_done; be = n_err;
        send(8'hA5);
        device(20, 5, 1'b0, cap, ok);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("rst_async_ready", 32'(tx_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_pulse", 32'(n_done + n_err), 32'(bd + be));
        send(PS2_CMD_SET_LED);
        device(20, 11, 1'b1, cap, ok);
        wait_end(bd + be);
        check("post_rst_bits", 32'(cap), 32'h7DA);
        check("post_rst_done", 32'(n_done - bd), 32'd1);

        // randomized frames
        for (int k = 0; k < 5; k++) begin
            b    = 8'($urandom_range(0, 255));
            half = $urandom_range(8, 30);
            ack  = ($urandom_range(0, 3) != 0);
            bd = n_done; be = n_err;
            repeat ($urandom_range(1, 20)) @(negedge clk);
            send(b);
            device(half, 11, ack, cap, ok);
            wait_end(bd + be);
            check("rand_bits", 32'(cap), 32'(frame_bits(b)));
            check("rand_done", 32'(n_done - bd), 32'(ack));
            check("rand_err", 32'(n_err - be), 32'(!ack));
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
